// File: rtl/sdram_arbiter.sv
// Multi-channel arbiter in front of a single-port SDRAM controller.
// Fixed-priority or round-robin grant, one outstanding access, wait-cycle timeout.
module sdram_arbiter #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned AW      = 25,
  parameter int unsigned DW      = 8,
  parameter int unsigned RR      = 0,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_we,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_din,
  output logic [NCH-1:0]    ch_ack,
  output logic              ch_err,
  output logic [DW-1:0]     ch_dout,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_din,
  output logic              mem_rd,
  output logic              mem_we,
  input  logic              mem_done,
  input  logic [DW-1:0]     mem_dout,
  output logic              busy
);

  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   last_q, last_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   din_q, din_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NCH-1:0]  ack_q, ack_d;
  logic            err_q, err_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic            busy_q, busy_d;

  logic            pick_vld;
  logic [IW-1:0]   pick;

  // Winner search: plain upward scan in fixed mode, scan from last_grant+1 in round-robin.
  always_comb begin
    int unsigned idx;
    logic        found;
    pick_vld = |ch_req;
    pick     = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = (RR != 0) ? ((32'(last_q) + 32'd1 + i) % NCH) : i;
      if (!found && ch_req[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    err_d   = 1'b0;
    dout_d  = dout_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = ISSUE;
          win_d   = pick;
          we_d    = ch_we[pick];
          addr_d  = ch_addr[32'(pick)*AW +: AW];
          din_d   = ch_din[32'(pick)*DW +: DW];
          rd_d    = ~ch_we[pick];
          wr_d    = ch_we[pick];
          cnt_d   = '0;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // Completion wins over a timeout that lands in the same cycle.
        if (mem_done) begin
          state_d      = IDLE;
          ack_d[win_q] = 1'b1;
          last_d       = win_q;
          if (!we_q) dout_d = mem_dout;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d      = IDLE;
          ack_d[win_q] = 1'b1;
          err_d        = 1'b1;
          last_d       = win_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      last_q  <= IW'(NCH - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      dout_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
    end
  end

  assign ch_ack   = ack_q;
  assign ch_err   = err_q;
  assign ch_dout  = dout_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign mem_rd   = rd_q;
  assign mem_we   = wr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench: fixed-priority instance (NCH=2, TIMEOUT=4) and round-robin instance (NCH=4).
module tb_sdram_arbiter;

  localparam int unsigned AW = 25;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Fixed-priority instance
  logic [1:0]    f_req, f_we, f_ack;
  logic [2*AW-1:0] f_addr;
  logic [2*DW-1:0] f_din;
  logic          f_err, f_rd, f_wr, f_done, f_busy;
  logic [DW-1:0] f_dout, f_mdin, f_mdout;
  logic [AW-1:0] f_maddr;

  // Round-robin instance
  logic [3:0]    r_req, r_we, r_ack;
  logic [4*AW-1:0] r_addr;
  logic [4*DW-1:0] r_din;
  logic          r_err, r_rd, r_wr, r_done, r_busy;
  logic [DW-1:0] r_dout, r_mdin, r_mdout;
  logic [AW-1:0] r_maddr;

  sdram_arbiter #(.NCH(2), .AW(AW), .DW(DW), .RR(0), .TIMEOUT(4)) u_fix (
    .clk_sys(clk), .rst_n(rst_n), .ch_req(f_req), .ch_we(f_we), .ch_addr(f_addr),
    .ch_din(f_din), .ch_ack(f_ack), .ch_err(f_err), .ch_dout(f_dout),
    .mem_addr(f_maddr), .mem_din(f_mdin), .mem_rd(f_rd), .mem_we(f_wr),
    .mem_done(f_done), .mem_dout(f_mdout), .busy(f_busy)
  );

  sdram_arbiter #(.NCH(4), .AW(AW), .DW(DW), .RR(1), .TIMEOUT(255)) u_rr (
    .clk_sys(clk), .rst_n(rst_n), .ch_req(r_req), .ch_we(r_we), .ch_addr(r_addr),
    .ch_din(r_din), .ch_ack(r_ack), .ch_err(r_err), .ch_dout(r_dout),
    .mem_addr(r_maddr), .mem_din(r_mdin), .mem_rd(r_rd), .mem_we(r_wr),
    .mem_done(r_done), .mem_dout(r_mdout), .busy(r_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    f_req  = '0; f_we = '0; f_addr = '0; f_din = '0; f_done = 1'b0; f_mdout = '0;
    r_req  = '0; r_we = '0; r_addr = '0; r_din = '0; r_done = 1'b0; r_mdout = '0;
    step(); step();

    // Reset state
    check("rst_ack",   64'(f_ack),   64'h0);
    check("rst_err",   64'(f_err),   64'h0);
    check("rst_busy",  64'(f_busy),  64'h0);
    check("rst_strb",  64'({f_rd, f_wr}), 64'h0);
    check("rst_maddr", 64'(f_maddr), 64'h0);
    check("rst_mdin",  64'(f_mdin),  64'h0);
    check("rst_dout",  64'(f_dout),  64'h0);
    check("rst_rr_busy", 64'(r_busy), 64'h0);
    rst_n = 1'b1;
    step();

    // Fixed priority: ch0 write 0x10/A5 and ch1 read 0x20 together, done 2 cycles after strobe
    f_req = 2'b11; f_we = 2'b01;
    f_addr[0 +: AW] = 25'h10; f_din[0 +: DW] = 8'hA5;
    f_addr[AW +: AW] = 25'h20; f_din[DW +: DW] = 8'h00;
    step();
    check("fx0_strobe", 64'({f_rd, f_wr}), 64'h1);
    check("fx0_maddr",  64'(f_maddr), 64'h10);
    check("fx0_mdin",   64'(f_mdin),  64'hA5);
    check("fx0_busy",   64'(f_busy),  64'h1);
    step();
    check("fx0_strobe_off", 64'({f_rd, f_wr}), 64'h0);
    check("fx0_addr_hold",  64'(f_maddr), 64'h10);
    check("fx0_no_ack",     64'(f_ack),   64'h0);
    step();
    f_done = 1'b1; f_mdout = 8'h77;
    step();
    f_done = 1'b0;
    check("fx0_ack",  64'(f_ack),  64'h1);
    check("fx0_err",  64'(f_err),  64'h0);
    check("fx0_dout_write_unchanged", 64'(f_dout), 64'h0);
    f_req[0] = 1'b0;
    step();
    check("fx1_strobe", 64'({f_rd, f_wr}), 64'h2);
    check("fx1_maddr",  64'(f_maddr), 64'h20);
    check("fx1_no_ack", 64'(f_ack),   64'h0);
    step();
    step();
    f_done = 1'b1; f_mdout = 8'h3C;
    step();
    f_done = 1'b0;
    check("fx1_ack",  64'(f_ack),  64'h2);
    check("fx1_err",  64'(f_err),  64'h0);
    check("fx1_dout", 64'(f_dout), 64'h3C);
    f_req = 2'b00;
    step();
    check("fx_idle_busy", 64'(f_busy), 64'h0);
    check("fx_idle_ack",  64'(f_ack),  64'h0);

    // Timeout: ch0 read, no mem_done; ack+err five cycles after ISSUE
    f_req = 2'b01; f_we = 2'b00; f_addr[0 +: AW] = 25'h33;
    step();
    check("to_strobe", 64'({f_rd, f_wr}), 64'h2);
    step(); step(); step();
    f_mdout = 8'hEE;
    step();
    check("to_not_early", 64'(f_ack), 64'h0);
    check("to_busy",      64'(f_busy), 64'h1);
    step();
    check("to_ack",  64'(f_ack),  64'h1);
    check("to_err",  64'(f_err),  64'h1);
    check("to_dout", 64'(f_dout), 64'h3C);
    f_req = 2'b00;
    step();
    check("to_err_pulse", 64'(f_err), 64'h0);

    // mem_done coinciding with the timeout cycle: normal completion, data captured
    f_req = 2'b01; f_addr[0 +: AW] = 25'h44;
    step();
    check("co_maddr", 64'(f_maddr), 64'h44);
    step(); step(); step();
    step();
    check("co_not_early", 64'(f_ack), 64'h0);
    f_done = 1'b1; f_mdout = 8'h99;
    step();
    f_done = 1'b0;
    check("co_ack",  64'(f_ack),  64'h1);
    check("co_err",  64'(f_err),  64'h0);
    check("co_dout", 64'(f_dout), 64'h99);
    f_req = 2'b00;
    step();

    // ch1 drops its request while ch0 is served; minimum latency; stray mem_done in IDLE
    f_req = 2'b11; f_we = 2'b11; f_addr[0 +: AW] = 25'h50; f_addr[AW +: AW] = 25'h60;
    step();
    check("dr_maddr", 64'(f_maddr), 64'h50);
    f_req[1] = 1'b0;
    step();
    f_done = 1'b1;
    step();
    f_done = 1'b0;
    check("dr_ack_lat3", 64'(f_ack), 64'h1);
    f_req = 2'b00;
    step();
    check("dr_idle_busy", 64'(f_busy), 64'h0);
    check("dr_no_ack1",   64'(f_ack),  64'h0);
    f_done = 1'b1;
    step();
    f_done = 1'b0;
    check("stray_done_ack",  64'(f_ack),  64'h0);
    check("stray_done_busy", 64'(f_busy), 64'h0);

    // Round-robin: all four requesting -> grants 0,1,2,3,0
    for (int i = 0; i < 4; i++) begin
      r_addr[i*AW +: AW] = 25'(32'h100 + i);
      r_din[i*DW +: DW]  = 8'(8'h10 + i);
    end
    r_we  = 4'b0000;
    r_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("rr%0d_maddr", k), 64'(r_maddr), 64'(32'h100 + (k % 4)));
      check($sformatf("rr%0d_rd", k), 64'({r_rd, r_wr}), 64'h2);
      step();
      r_done = 1'b1; r_mdout = 8'(8'hD0 + k);
      step();
      r_done = 1'b0;
      check($sformatf("rr%0d_ack", k), 64'(r_ack), 64'(4'b0001 << (k % 4)));
      check($sformatf("rr%0d_dout", k), 64'(r_dout), 64'(8'hD0 + k));
      if (k == 4) r_req = 4'b1001;
    end
    // last grant was 0: scan from 1 skips 1,2 and picks 3
    step();
    check("rr_skip_maddr", 64'(r_maddr), 64'h103);
    r_req = 4'b0000;
    step();
    r_done = 1'b1;
    step();
    r_done = 1'b0;
    check("rr_skip_ack", 64'(r_ack), 64'h8);

    // Reset during WAIT abandons the access; later mem_done ignored
    step();
    f_req = 2'b01; f_we = 2'b00; f_addr[0 +: AW] = 25'h60;
    step();
    check("rw_strobe", 64'({f_rd, f_wr}), 64'h2);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; f_req = 2'b00; f_done = 1'b1; f_mdout = 8'h5A;
    step();
    f_done = 1'b0;
    check("rw_ack",   64'(f_ack),   64'h0);
    check("rw_busy",  64'(f_busy),  64'h0);
    check("rw_maddr", 64'(f_maddr), 64'h0);
    check("rw_mdin",  64'(f_mdin),  64'h0);
    check("rw_dout",  64'(f_dout),  64'h0);
    check("rw_err",   64'(f_err),   64'h0);
    step();
    check("rw_ack_late", 64'(f_ack), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // One-hot acks and exclusive strobes on every cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (!$onehot0(f_ack) || !$onehot0(r_ack) || (f_rd && f_wr) || (r_rd && r_wr)) begin
        n_tests++;
        n_fail++;
        $display("FAIL exclusivity: f_ack=%b r_ack=%b f_rd/we=%b%b r_rd/we=%b%b required one-hot/exclusive",
                 f_ack, r_ack, f_rd, f_wr, r_rd, r_wr);
      end
    end
  end

endmodule
